// File: rtl/act_pkg.sv
// act_pkg: shared constants, FSM encoding and skid-FIFO entry layout for act_fetch.
package act_pkg;
    localparam int LANES = 16;
    localparam int ROWS  = 64;
    localparam int AW    = 6;
    localparam int QW    = 4;
    localparam int SFW   = 18;
    localparam int OW    = QW + SFW;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    typedef struct packed {
        logic [LANES-1:0][OW-1:0] data;
        logic [AW-1:0]            row;
        logic                     last;
    } fifo_entry_t;
endpackage

// File: rtl/act_skid_fifo.sv
// act_skid_fifo: 2-entry FIFO that absorbs the RAM read latency; head entry drives the outputs directly.
module act_skid_fifo
    import act_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  fifo_entry_t i_din,
    input  logic        i_pop,
    output fifo_entry_t o_dout,
    output logic        o_valid,
    output logic [1:0]  o_cnt
);
    fifo_entry_t r_head;
    fifo_entry_t r_tail;
    logic [1:0]  r_cnt;
    logic        r_valid;
    logic        w_pop;

    assign w_pop = i_pop && r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_din;
                    else               r_tail <= i_din;
                    r_cnt   <= r_cnt + 2'd1;
                    r_valid <= 1'b1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_cnt   <= r_cnt - 2'd1;
                    r_valid <= (r_cnt == 2'd2);
                end
                2'b11: begin
                    // count unchanged: new entry lands behind whatever remains
                    if (r_cnt == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dout  = r_head;
    assign o_valid = r_valid;
    assign o_cnt   = r_cnt;
endmodule

// File: rtl/act_fetch.sv
// act_fetch: reads one quantized tile from the activation RAM, dequantizes per lane and streams rows out.
// Define ACT_FETCH_SF_DBUF_EN for double-buffered scale factors; default is a single bank.
module act_fetch
    import act_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    input  logic [SFW*LANES-1:0]  i_sf_data,
    input  logic                  i_sf_valid,
    output logic                  o_sf_drop,
    output logic                  o_ram_re,
    output logic [AW-1:0]         o_ram_addr,
    input  logic [QW*LANES-1:0]   i_ram_data,
    output logic [OW*LANES-1:0]   o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [AW-1:0]         o_row,
    output logic                  o_last,
    output logic                  o_done
);
    state_t                    r_state;
    logic                      r_busy;
    logic                      r_done;
    logic [AW:0]               r_rd_addr;
    logic                      r_inflight;
    logic [AW-1:0]             r_inflight_row;
    logic [LANES-1:0][SFW-1:0] r_sf_act;
    logic [LANES-1:0][QW-1:0]  w_q;
    logic [LANES-1:0][OW-1:0]  w_prod;
    fifo_entry_t               w_push_entry;
    fifo_entry_t               w_head;
    logic [1:0]                w_cnt;
    logic                      w_valid;
    logic                      w_hs;
    logic                      w_re;
    logic                      w_start;

    assign w_q     = i_ram_data;
    assign w_hs    = w_valid && i_ready;
    assign w_start = (r_state == S_IDLE) && i_start;
    // count + inflight never exceeds 2, so a read is safe only with room or a pop this cycle
    assign w_re    = (r_state == S_BUSY) && !r_rd_addr[AW] &&
                     (((3'(w_cnt) + 3'(r_inflight)) < 3'd2) || w_hs);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_prod[g] = $signed({{SFW{w_q[g][QW-1]}}, w_q[g]}) *
                           $signed({{QW{r_sf_act[g][SFW-1]}}, r_sf_act[g]});
    end

    assign w_push_entry = '{data: w_prod, row: r_inflight_row,
                            last: (r_inflight_row == AW'(ROWS-1))};

    act_skid_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_inflight),
        .i_din   (w_push_entry),
        .i_pop   (i_ready),
        .o_dout  (w_head),
        .o_valid (w_valid),
        .o_cnt   (w_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_rd_addr      <= '0;
            r_inflight     <= 1'b0;
            r_inflight_row <= '0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_re;
            if (w_re) begin
                r_inflight_row <= r_rd_addr[AW-1:0];
                r_rd_addr      <= r_rd_addr + {{AW{1'b0}}, 1'b1};
            end
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state   <= S_BUSY;
                    r_busy    <= 1'b1;
                    r_rd_addr <= '0;
                end
                S_BUSY: if (w_hs && w_head.last) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ACT_FETCH_SF_DBUF_EN
    logic [LANES-1:0][SFW-1:0] r_sf_shadow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sf_shadow <= '0;
            r_sf_act    <= '0;
        end else begin
            if (i_sf_valid) r_sf_shadow <= i_sf_data;
            // bypass so a scale update arriving with start is used by that tile
            if (w_start)    r_sf_act    <= i_sf_valid ? i_sf_data : r_sf_shadow;
        end
    end

    assign o_sf_drop = 1'b0;
`else
    logic r_sf_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sf_act  <= '0;
            r_sf_drop <= 1'b0;
        end else begin
            r_sf_drop <= i_sf_valid && (r_state == S_BUSY);
            if (i_sf_valid && (r_state == S_IDLE)) r_sf_act <= i_sf_data;
        end
    end

    assign o_sf_drop = r_sf_drop;
`endif

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_ram_re   = w_re;
    assign o_ram_addr = r_rd_addr[AW-1:0];
    assign o_data     = w_head.data;
    assign o_row      = w_head.row;
    assign o_last     = w_head.last && w_valid;
    assign o_valid    = w_valid;
endmodule

// File: tb/tb_act_fetch.sv
// tb_act_fetch: table vectors, hand sequences and a randomized backpressure tile scored against an arithmetic model.
`timescale 1ns/1ps
module tb_act_fetch;
    import act_pkg::*;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_start = 1'b0;
    logic                 i_sf_valid = 1'b0;
    logic                 i_ready = 1'b1;
    logic [SFW*LANES-1:0] i_sf_data = '0;
    logic [QW*LANES-1:0]  i_ram_data = '0;
    logic                 o_busy, o_sf_drop, o_ram_re, o_valid, o_last, o_done;
    logic [AW-1:0]        o_ram_addr, o_row;
    logic [OW*LANES-1:0]  o_data;

    act_fetch dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .o_busy(o_busy),
        .i_sf_data(i_sf_data), .i_sf_valid(i_sf_valid), .o_sf_drop(o_sf_drop),
        .o_ram_re(o_ram_re), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_row(o_row),
        .o_last(o_last), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // reference state: quantized tile contents and the scale set the running tile must use
    int                  mem_q [ROWS][LANES];
    int                  tile_sf [LANES];
    int                  sf_next [LANES];
    logic [QW*LANES-1:0] ram [ROWS];

    int  start_cyc, exp_row, first_vld_cyc, done_cnt, done_cyc, issued, popped, drop_cyc, mn;
    bit  mon_en = 1'b0, bp_en = 1'b0, prev_stall, re_s, want_drop;
    logic [OW*LANES-1:0] prev_data, row0_data;
    logic [AW-1:0]       prev_row;
    logic                prev_last;
    logic [QW*LANES-1:0] d_s;

    typedef struct { int q; int sf; int expv; } vec_t;
    vec_t vecs [6];

    function automatic logic [OW*LANES-1:0] exp_row_data(input int r);
        logic [OW*LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*OW +: OW] = OW'(mem_q[r][i] * tile_sf[i]);
        return v;
    endfunction

    function automatic logic [SFW*LANES-1:0] pack_sf();
        logic [SFW*LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*SFW +: SFW] = SFW'(sf_next[i]);
        return v;
    endfunction

    task automatic load_ram();
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < LANES; i++) ram[r][i*QW +: QW] = QW'(mem_q[r][i]);
    endtask

    task automatic set_sf();
        @(posedge i_clk); #2;
        i_sf_data = pack_sf(); i_sf_valid = 1'b1;
        @(posedge i_clk); #2;
        i_sf_valid = 1'b0;
    endtask

    // one-cycle RAM latency: capture the request during the cycle, present data in the next
    initial forever begin
        @(negedge i_clk);
        re_s = o_ram_re; d_s = ram[o_ram_addr];
        @(posedge i_clk); #1;
        if (re_s) i_ram_data = d_s;
    end

    initial forever begin
        @(posedge i_clk); #1;
        i_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge i_clk);
        if (mon_en) begin
            mn = cyc - start_cyc;
            if (prev_stall) begin
                checks++;
                if (!o_valid || o_data !== prev_data || o_row !== prev_row || o_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got row=%0d valid=%b want row=%0d", mn, o_row, o_valid, prev_row);
                end
            end
            if (o_valid && first_vld_cyc < 0) first_vld_cyc = mn;
            if (o_ram_re) issued++;
            if (o_valid && i_ready) begin
                checks++;
                if (exp_row >= ROWS) begin
                    errors++;
                    $display("FAIL extra_row got row=%0d after %0d rows", o_row, exp_row);
                end else if (o_row !== AW'(exp_row) || o_data !== exp_row_data(exp_row) ||
                             o_last !== (exp_row == ROWS-1)) begin
                    errors++;
                    $display("FAIL row_data got row=%0d last=%b lane0=%0d want row=%0d lane0=%0d", o_row, o_last,
                             $signed(o_data[OW-1:0]), exp_row, mem_q[exp_row][0] * tile_sf[0]);
                end
                if (exp_row == 0) row0_data = o_data;
                exp_row++; popped++;
            end
            checks++;
            if (issued - popped > 2) begin
                errors++;
                $display("FAIL read_ahead cyc=%0d got %0d rows ahead want <=2", mn, issued - popped);
            end
            want_drop = (drop_cyc >= 0) && (mn == drop_cyc);
            checks++;
            if (o_sf_drop !== want_drop) begin
                errors++;
                $display("FAIL sf_drop cyc=%0d got %b want %b", mn, o_sf_drop, want_drop);
            end
            if (o_done) begin
                done_cnt++; done_cyc = mn;
                checks++;
                if (exp_row != ROWS) begin
                    errors++;
                    $display("FAIL done_early got done after %0d rows want %0d", exp_row, ROWS);
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_data = o_data; prev_row = o_row; prev_last = o_last;
        end
    end

    task automatic run_tile(input int extra_start, input int sf_cyc, input logic [SFW*LANES-1:0] sf_new,
                            input bit chk_timing, input int abort_row);
        int n, guard;
        @(posedge i_clk); #2;
        exp_row = 0; first_vld_cyc = -1; done_cnt = 0; done_cyc = -1;
        issued = 0; popped = 0; prev_stall = 1'b0;
`ifdef ACT_FETCH_SF_DBUF_EN
        drop_cyc = -1;
`else
        drop_cyc = (sf_cyc >= 0) ? sf_cyc + 1 : -1;
`endif
        start_cyc = cyc; mon_en = 1'b1; i_start = 1'b1;
        guard = 0;
        while (done_cnt == 0 && guard < 600) begin
            @(posedge i_clk); #2; guard++;
            n = cyc - start_cyc;
            i_start = (n == extra_start);
            i_sf_valid = (n == sf_cyc);
            if (n == sf_cyc) i_sf_data = sf_new;
            if (abort_row >= 0 && exp_row >= abort_row) begin
                mon_en = 1'b0; i_start = 1'b0; i_sf_valid = 1'b0;
                i_rst_n = 1'b0; #1;
                checks++;
                if ({o_busy, o_ram_re, o_valid, o_last, o_done, o_sf_drop, o_ram_addr, o_row, o_data} !== '0) begin
                    errors++;
                    $display("FAIL abort_reset got busy=%b re=%b valid=%b row=%0d addr=%0d want all 0",
                             o_busy, o_ram_re, o_valid, o_row, o_ram_addr);
                end
                @(posedge i_clk); #2;
                i_rst_n = 1'b1;
                return;
            end
        end
        i_start = 1'b0; i_sf_valid = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL tile_timeout got %0d rows want done", exp_row);
        end
        repeat (3) @(posedge i_clk);
        #2; mon_en = 1'b0;
        checks++;
        if (exp_row != ROWS) begin errors++; $display("FAIL rows_seen got %0d want %0d", exp_row, ROWS); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", done_cnt); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_after got %b want 0", o_busy); end
        if (chk_timing) begin
            checks++;
            if (first_vld_cyc != 3) begin errors++; $display("FAIL first_valid got cyc %0d want 3", first_vld_cyc); end
            checks++;
            if (done_cyc != 67) begin errors++; $display("FAIL done_cycle got cyc %0d want 67", done_cyc); end
        end
    endtask

    initial begin
        logic [SFW*LANES-1:0] sf_a, sf_b;
        vecs[0] = '{-8, -131072,  1048576};
        vecs[1] = '{ 7,  131071,   917497};
        vecs[2] = '{-8,  131071, -1048568};
        vecs[3] = '{ 7, -131072,  -917504};
        vecs[4] = '{-1,       1,       -1};
        vecs[5] = '{ 3,      -5,      -15};

        repeat (3) @(posedge i_clk);
        #2;
        checks++;
        if ({o_busy, o_ram_re, o_valid, o_last, o_done, o_sf_drop, o_ram_addr, o_row, o_data} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b re=%b valid=%b want all 0", o_busy, o_ram_re, o_valid);
        end
        i_rst_n = 1'b1;

        // ramp pattern, ready always high
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < LANES; i++) mem_q[r][i] = ((r + i) % 16) - 8;
        load_ram();
        for (int i = 0; i < LANES; i++) begin sf_next[i] = 1000 * (i + 1); tile_sf[i] = sf_next[i]; end
        set_sf();
        run_tile(-1, -1, '0, 1'b1, -1);

        // extreme products, one vector per tile
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < LANES; i++) mem_q[r][i] = vecs[k].q;
            load_ram();
            for (int i = 0; i < LANES; i++) begin sf_next[i] = vecs[k].sf; tile_sf[i] = vecs[k].sf; end
            set_sf();
            run_tile(-1, -1, '0, 1'b1, -1);
            checks++;
            if (row0_data[OW-1:0] !== OW'(vecs[k].expv)) begin
                errors++;
                $display("FAIL vec%0d_lane0 got %0d want %0d", k, $signed(row0_data[OW-1:0]), vecs[k].expv);
            end
        end

        // random data and scales under random backpressure
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < LANES; i++) mem_q[r][i] = int'($urandom_range(0, 15)) - 8;
        load_ram();
        for (int i = 0; i < LANES; i++) begin
            sf_next[i] = int'($urandom_range(0, 262143)) - 131072; tile_sf[i] = sf_next[i];
        end
        set_sf();
        bp_en = 1'b1;
        run_tile(-1, -1, '0, 1'b0, -1);
        bp_en = 1'b0;

        // second start while busy is ignored
        run_tile(10, -1, '0, 1'b1, -1);

        // scale update mid-tile
        for (int i = 0; i < LANES; i++) begin sf_next[i] = 1000 * (i + 1); tile_sf[i] = sf_next[i]; end
        set_sf();
        sf_a = pack_sf();
        for (int i = 0; i < LANES; i++) sf_next[i] = -777 * (i + 3);
        sf_b = pack_sf();
        run_tile(-1, 20, sf_b, 1'b1, -1);
`ifdef ACT_FETCH_SF_DBUF_EN
        for (int i = 0; i < LANES; i++) tile_sf[i] = sf_next[i];
`endif
        run_tile(-1, -1, '0, 1'b1, -1);
        checks++;
        if (sf_a === sf_b) begin errors++; $display("FAIL sf_sets got identical want distinct"); end

        // reset at row 30, then a clean tile from row 0
        run_tile(-1, -1, '0, 1'b0, 30);
        for (int i = 0; i < LANES; i++) begin sf_next[i] = 1000 * (i + 1); tile_sf[i] = sf_next[i]; end
        set_sf();
        run_tile(-1, -1, '0, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/act_fetch.md
# act_fetch

Reader side of the PPU output path. Fetches one quantized tile (64 rows × 16 INT4 lanes) from the output activation RAM that the PPU writes, and captures the per-lane INT18 scale factors the PPU emits. Dequantizes each row to INT22 per lane and streams it to the next layer's PE-array input over a valid/ready handshake. A 2-entry skid FIFO absorbs the 1-cycle RAM read latency so downstream backpressure never loses data.

## Interface
- LANES, 16, vector lanes per row
- ROWS, 64, rows per tile
- AW, 6, RAM address width (log2 ROWS)
- QW, 4, quantized element width (signed)
- SFW, 18, scale-factor width (signed)
- OW, QW+SFW = 22, dequantized element width (signed)

- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; launches a tile read
- o_busy  out  1  high from start acceptance until o_done
- i_sf_data  in  SFW*LANES  per-lane scale factors
- i_sf_valid  in  1  i_sf_data valid this cycle
- o_sf_drop  out  1  pulse: i_sf_valid was discarded
- o_ram_re  out  1  RAM read enable
- o_ram_addr  out  AW  RAM read address
- i_ram_data  in  QW*LANES  read data, valid the cycle after o_ram_re
- o_data  out  OW*LANES  dequantized row, lane i at [i*OW +: OW]
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_row  out  AW  row index of o_data
- o_last  out  1  o_data is row ROWS-1
- o_done  out  1  one-cycle pulse after the last row's handshake

## Operation
- FSM: S_IDLE, S_BUSY.
  - S_IDLE → S_BUSY on i_start.
  - S_BUSY → S_IDLE in the cycle after the handshake of row ROWS-1; o_done pulses in that cycle.
- i_start in S_BUSY is ignored.
- Read issue: rd_addr counts 0..ROWS-1 and is not issued past ROWS-1.
  - o_ram_re=1 when S_BUSY, rd_addr<ROWS, and (fifo_cnt + inflight < 2 or an output handshake occurs this cycle).
  - inflight = registered o_ram_re.
- Dequant, per lane: $signed(q[i]) * $signed(sf[i]). Exact INT22 result; no rounding or saturation. Result is written into the FIFO on the cycle the RAM data returns.
- o_row and o_last travel with the data in the FIFO.
- Scale-factor capture: see Configuration. The active bank stays constant during a tile.
- Reset values: o_busy, o_ram_re, o_valid, o_last, o_done, o_sf_drop = 0. o_ram_addr, o_row, o_data = 0. FIFO empty. Scale banks = 0.
- Reset mid-tile aborts immediately. No o_done. The next i_start restarts at row 0.

## Timing
- i_start sampled at cycle 0:
  - cycle 1: o_ram_re=1, addr 0.
  - cycle 2: RAM data returns and is written to the FIFO.
  - cycle 3: o_valid=1 with row 0.
- With i_ready held high: one row per cycle, rows 0..63 on cycles 3..66. o_done at cycle 67. A new i_start is accepted at cycle 67 or later.
- While o_valid && !i_ready, o_data, o_row and o_last hold stable.
- RAM reads stall so the FIFO never overflows. FIFO count never exceeds 2.
- Simultaneous FIFO push and pop keeps the count unchanged.

## Configuration
- ACT_FETCH_SF_DBUF_EN defined (double-buffered scale factors):
  - i_sf_valid writes a shadow bank in any state.
  - The active bank loads from the shadow on start acceptance. If i_sf_valid coincides with start, the new i_sf_data goes to both banks (bypass).
  - o_sf_drop is tied to 0.
- Not defined (single bank):
  - i_sf_valid writes the active bank only in S_IDLE.
  - In S_BUSY it is discarded, and o_sf_drop pulses in the following cycle.

## Structure
- Shared package act_pkg holds:
  - LANES, ROWS, QW, SFW, OW, AW constants.
  - FSM state encoding.
  - FIFO entry struct {data, row, last}.
- One sub-module: act_skid_fifo. 2-entry synchronous FIFO with push, pop, count, and registered outputs.
- Dequant multipliers are inline generate lanes.

## Test plan
- Tile of row r, lane i = (r+i)%16-8 as INT4; sf lane i = 1000*(i+1); i_ready=1 → 64 rows on cycles 3..66, each lane equal to the exact product, o_last on row 63, o_done at cycle 67.
- Extremes: q=-8, sf=-131072 → lane = +1048576. q=7, sf=131071 → 917497.
- Backpressure: i_ready toggles 1,0,0,1 pseudo-randomly → all 64 rows in order with no duplicates; data stable while stalled; RAM never reads more than 2 rows ahead of output.
- i_start pulsed at cycle 10 of a running tile → ignored; exactly 64 rows and one o_done.
- i_sf_valid at cycle 20 of a tile:
  - Macro defined: the current tile uses the old sf, the next tile uses the new sf, o_sf_drop=0.
  - Macro undefined: o_sf_drop pulses at cycle 21, both tiles use the old sf.
- i_rst_n low at row 30 → all outputs 0 asynchronously; next i_start outputs row 0 first at cycle 3.
